inst_fetch_mod: RTL

INST_FETCH_MOD -- requirements
Module: inst_fetch_mod

---
 rtl/inst_fetch_mod.sv | 139 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_mod.sv
// inst_fetch_mod: instruction prefetch unit.
// Fetches opcode bytes from a request/ack byte bus into a small FIFO and
// presents the head byte together with its program address.
// Ports:
//   clock, reset           : rising-edge clock; async active-high reset
//   adv                    : consume the head opcode at this edge
//   pc_load, pc_load_value : redirect the fetch stream to a new address
//   inst_buffer/inst_valid : head byte (8'h00 when empty) and its valid flag
//   pc                     : address of the byte on inst_buffer
//   mem_rd_req/mem_addr    : bus read request; held until acked
//   mem_rd_ack/mem_rd_data : bus completion with same-cycle data
module inst_fetch_mod #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2          // 2 or 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        adv,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic [7:0]  inst_buffer,
  output logic        inst_valid,
  output logic [15:0] pc,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t                      state, state_nxt;
  logic [15:0]                 fetch_addr, fetch_nxt;
  logic [15:0]                 addr_nxt;
  logic [FIFO_DEPTH-1:0][7:0]  fifo;
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic [CW-1:0]               count, count_nxt;
  logic                        full, ack, push, pop;

  assign full = (count == DEPTH_C);
  assign ack  = mem_rd_req && mem_rd_ack;
  // A redirect wins over a same-cycle consume, and any data returning with
  // the redirect belongs to the old stream.
  assign pop  = adv && (count != '0) && !pc_load;
  assign push = (state == FETCH) && ack && !pc_load && (!full || pop);

  // Head is read straight out of FIFO storage; never from the bus.
  assign inst_valid  = (count != '0);
  assign inst_buffer = inst_valid ? fifo[rd_ptr] : 8'h00;

  always_comb begin
    count_nxt = count;
    if (pc_load)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_comb begin
    fetch_nxt = fetch_addr;
    if (pc_load)
      fetch_nxt = pc_load_value;
    else if (push)
      fetch_nxt = fetch_addr + 16'd1;   // wraps FFFF -> 0000
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // pop frees a slot this cycle, so a new fetch can start immediately
        if (pc_load || !full || pop)
          state_nxt = FETCH;
      end
      FETCH: begin
        if (pc_load)
          // an acked request is simply dropped; an unacked one must be
          // completed on the bus and thrown away
          state_nxt = ack ? FETCH : DISCARD;
        else if (ack)
          state_nxt = (count_nxt < DEPTH_C) ? FETCH : IDLE;
      end
      DISCARD: begin
        if (ack)
          state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The bus address only moves when a new request is issued; in DISCARD it
  // holds the outstanding (stale) address until that request is acked.
  always_comb begin
    addr_nxt = mem_addr;
    if (state_nxt == FETCH)
      addr_nxt = fetch_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_rd_req <= 1'b0;
      mem_addr   <= RESET_PC;
      fetch_addr <= RESET_PC;
      pc         <= RESET_PC;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo       <= '0;
    end else begin
      state      <= state_nxt;
      mem_rd_req <= (state_nxt != IDLE);
      mem_addr   <= addr_nxt;
      fetch_addr <= fetch_nxt;
      count      <= count_nxt;
      if (pc_load) begin
        pc     <= pc_load_value;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) begin
          pc     <= pc + 16'd1;
          rd_ptr <= rd_ptr + 1'b1;      // power-of-2 depth: natural wrap
        end
        if (push) begin
          fifo[wr_ptr] <= mem_rd_data;
          wr_ptr       <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule
